gray_code_converter: RTL



---
 rtl/gray_conv_pkg.sv | 18 +
 rtl/gray_conv_slice.sv | 28 ++
 rtl/gray_code_converter.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/gray_conv_pkg.sv
// Shared types and helpers for the bit-sliced Binary<->Gray converter.
package gray_conv_pkg;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StProc = 2'd1,
      StDone = 2'd2
   } state_t;

   localparam logic MODE_B2G = 1'b0;
   localparam logic MODE_G2B = 1'b1;

   // True when bpc is a legal slice size for a word of the given width.
   function automatic bit bpc_divides(input int unsigned width, input int unsigned bpc);
      return (bpc != 0) && (bpc <= width) && ((width % bpc) == 0);
   endfunction

endpackage

// File: rtl/gray_conv_slice.sv
// Combinational BITS-wide conversion step, resolved MSB-first from a carry bit.
module gray_conv_slice
   import gray_conv_pkg::*;
#(
   parameter int unsigned BITS = 1
) (
   input  logic [BITS-1:0] src,
   input  logic            carry_in,
   input  logic            mode,
   output logic [BITS-1:0] res,
   output logic            carry_out
);

   logic up;

   // up is the bit one position above the one being resolved: a source bit for
   // binary->Gray, an already-resolved result bit for Gray->binary.
   always_comb begin
      res = '0;
      up  = carry_in;
      for (int i = int'(BITS) - 1; i >= 0; i--) begin
         res[i] = src[i] ^ up;
         up     = (mode == MODE_G2B) ? res[i] : src[i];
      end
      carry_out = up;
   end

endmodule

// File: rtl/gray_code_converter.sv
// Serial MSB-first Binary<->Gray converter with valid/ready on both sides.
// Define GRAY_CONV_PARITY_EN to add the dout_parity output.
module gray_code_converter
   import gray_conv_pkg::*;
#(
   parameter int unsigned WIDTH          = 8,
   parameter int unsigned BITS_PER_CYCLE = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             convert,
   input  logic [WIDTH-1:0] din,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] dout,
   output logic             busy
`ifdef GRAY_CONV_PARITY_EN
   ,
   output logic             dout_parity
`endif
);

   localparam int unsigned B    = BITS_PER_CYCLE;
   localparam int unsigned IdxW = $clog2(WIDTH);

   localparam logic [IdxW-1:0] IdxTop  = IdxW'(WIDTH - 1);
   localparam logic [IdxW-1:0] IdxLow  = IdxW'(B - 1);
   localparam logic [IdxW-1:0] IdxStep = IdxW'(B);

   if (WIDTH < 2 || !bpc_divides(WIDTH, B)) begin : gen_param_err
      $error("gray_code_converter: WIDTH must be >= 2 and divisible by BITS_PER_CYCLE");
   end

   state_t          state_q, state_d;
   logic [IdxW-1:0] idx_q, idx_d;
   logic [WIDTH-1:0] src_q, src_d;
   logic [WIDTH-1:0] dout_q, dout_d;
   logic            mode_q, mode_d;
   logic            carry_q, carry_d;

   logic [IdxW-1:0] lsb;
   logic [B-1:0]    slice_src;
   logic [B-1:0]    slice_res;
   logic            slice_cout;
   int              idx_int;
   logic            idx_legal;
   logic            last_slice;
   logic            accept;

   assign lsb        = idx_q - IdxLow;
   assign slice_src  = B'(src_q >> lsb);
   assign idx_int    = int'(idx_q);
   assign idx_legal  = (idx_int < int'(WIDTH)) && (idx_int >= int'(B) - 1);
   assign last_slice = (idx_q == IdxLow);
   assign accept     = (state_q == StIdle) && in_valid;

   // carry_q holds src[idx+1] or dout[idx+1] from the previous slice, 0 above the MSB.
   gray_conv_slice #(
      .BITS (B)
   ) u_slice (
      .src       (slice_src),
      .carry_in  (carry_q),
      .mode      (mode_q),
      .res       (slice_res),
      .carry_out (slice_cout)
   );

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      src_d   = src_q;
      dout_d  = dout_q;
      mode_d  = mode_q;
      carry_d = carry_q;
      case (state_q)
         StIdle: begin
            if (in_valid) begin
               src_d   = din;
               mode_d  = convert;
               dout_d  = '0;
               idx_d   = IdxTop;
               carry_d = 1'b0;
               state_d = StProc;
            end
         end
         StProc: begin
            if (!idx_legal) begin
               idx_d   = IdxTop;
               state_d = StIdle;
            end else begin
               // dout was cleared at accept, so OR-ing each slice in is enough.
               dout_d  = dout_q | (WIDTH'(slice_res) << lsb);
               carry_d = slice_cout;
               if (last_slice) begin
                  state_d = StDone;
               end else begin
                  idx_d = idx_q - IdxStep;
               end
            end
         end
         StDone: begin
            if (out_ready) begin
               state_d = StIdle;
            end
         end
         default: begin
            idx_d   = IdxTop;
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         idx_q   <= IdxTop;
         src_q   <= '0;
         dout_q  <= '0;
         mode_q  <= MODE_B2G;
         carry_q <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         src_q   <= src_d;
         dout_q  <= dout_d;
         mode_q  <= mode_d;
         carry_q <= carry_d;
      end
   end

`ifdef GRAY_CONV_PARITY_EN
   logic parity_q, parity_d;

   always_comb begin
      parity_d = parity_q;
      if (accept) begin
         parity_d = 1'b0;
      end else if (state_q == StProc && idx_legal) begin
         parity_d = parity_q ^ (^slice_res);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         parity_q <= 1'b0;
      end else begin
         parity_q <= parity_d;
      end
   end

   assign dout_parity = parity_q;
`endif

   assign in_ready  = (state_q == StIdle);
   assign out_valid = (state_q == StDone);
   assign busy      = (state_q != StIdle);
   assign dout      = dout_q;

endmodule
